// File: rtl/shared_ram.sv
// Single-port RAM shared by NPORTS requesters through a round-robin arbiter; clears itself after reset.
// Read latency 1 cycle. Requesters hold req until gnt; nothing is granted while the clear runs.
module shared_ram #(
  parameter  int SIZE   = 256,
  parameter  int WORD   = 32,
  parameter  int NPORTS = 4,
  localparam int AW     = $clog2(SIZE),
  localparam int BE     = WORD / 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NPORTS-1:0]      req,
  input  logic [NPORTS-1:0]      we,
  input  logic [NPORTS*BE-1:0]   be,
  input  logic [NPORTS*AW-1:0]   addr,
  input  logic [NPORTS*WORD-1:0] wdata,
  output logic [NPORTS-1:0]      gnt,
  output logic [NPORTS-1:0]      rvalid,
  output logic [WORD-1:0]        rdata,
  output logic                   init_done
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     clr_cnt, clr_cnt_nxt;
  logic [PW-1:0]     ptr, ptr_nxt;
  logic              gnt_any;
  logic [PW-1:0]     gnt_idx;
  logic [AW-1:0]     addr_sel;
  logic [BE-1:0]     be_sel;
  logic [WORD-1:0]   wdata_sel;
  logic [WORD-1:0]   mem [SIZE];

  always_comb begin
    int idx;
    idx         = 0;
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    ptr_nxt     = ptr;
    gnt         = '0;
    gnt_any     = 1'b0;
    gnt_idx     = '0;
    case (state)
      INIT: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == AW'(SIZE - 1)) state_nxt = RUN;
      end
      RUN: begin
        // First requester at or after ptr, wrapping around
        for (int i = 0; i < NPORTS; i++) begin
          idx = (int'(ptr) + i) % NPORTS;
          if (!gnt_any && req[idx]) begin
            gnt_any  = 1'b1;
            gnt_idx  = PW'(idx);
            gnt[idx] = 1'b1;
          end
        end
        if (gnt_any) ptr_nxt = (int'(gnt_idx) == NPORTS - 1) ? '0 : gnt_idx + 1'b1;
      end
      default: state_nxt = INIT;
    endcase
  end

  assign addr_sel  = addr[int'(gnt_idx)*AW +: AW];
  assign be_sel    = be[int'(gnt_idx)*BE +: BE];
  assign wdata_sel = wdata[int'(gnt_idx)*WORD +: WORD];
  assign init_done = (state == RUN);

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[clr_cnt] <= '0;
    end else if (gnt_any && we[gnt_idx]) begin
      for (int b = 0; b < BE; b++)
        if (be_sel[b]) mem[addr_sel][b*8 +: 8] <= wdata_sel[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT;
      clr_cnt <= '0;
      ptr     <= '0;
      rvalid  <= '0;
      rdata   <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      ptr     <= ptr_nxt;
      rvalid  <= '0;
      if (gnt_any && !we[gnt_idx]) begin
        rvalid <= gnt;
        rdata  <= mem[addr_sel];
      end
    end
  end

endmodule
